// File: rtl/prog_loader.sv
// Program loader: takes a framed 16-bit word stream, pairs the words into 32-bit
// instructions, writes them to instruction memory, verifies the checksum and releases the core.
module prog_loader #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          sys_rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   in_data,
  output logic          im_we,
  output logic [AW-1:0] im_addr,
  output logic [31:0]   im_wdata,
  output logic          core_rst,
  output logic          done,
  output logic          err,
  output logic [AW:0]   word_count
);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    HI,
    LO,
    CHK,
    DONE,
    ERR
  } state_t;

  state_t        state;
  state_t        next_state;
  logic          accept;
  logic          session_start;
  logic          hdr_ok;
  logic          last_word;
  logic [AW:0]   n_reg;
  logic [AW-1:0] index;
  logic [15:0]   sum;
  logic [15:0]   hi_reg;

  assign accept        = in_valid && in_ready;
  assign session_start = start && ((state == IDLE) || (state == DONE) || (state == ERR));

  assign hdr_ok = (in_data[15:8] == 8'hA5) && (in_data[7:5] == 3'b000) &&
                  (in_data[4:0] != 5'd0) && (int'({27'b0, in_data[4:0]}) <= DEPTH);

  assign last_word = ({1'b0, index} == (n_reg - {{AW{1'b0}}, 1'b1}));

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Start is honoured only between sessions; mid-frame it is deliberately ignored.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = HDR;
      HDR:     if (accept) next_state = hdr_ok ? HI : ERR;
      HI:      if (accept) next_state = LO;
      LO:      if (accept) next_state = last_word ? CHK : HI;
      CHK:     if (accept) next_state = (in_data == sum) ? DONE : ERR;
      DONE:    if (start) next_state = HDR;
      ERR:     if (start) next_state = HDR;
      default: next_state = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      in_ready   <= 1'b0;
      im_we      <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= '0;
      core_rst   <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      word_count <= '0;
      index      <= '0;
      sum        <= '0;
      hi_reg     <= '0;
      n_reg      <= '0;
    end else begin
      im_we    <= 1'b0;
      in_ready <= (next_state == HDR) || (next_state == HI) ||
                  (next_state == LO)  || (next_state == CHK);
      done     <= (next_state == DONE);
      err      <= (next_state == ERR);
      core_rst <= (next_state != DONE);

      if (session_start) begin
        word_count <= '0;
        index      <= '0;
        sum        <= '0;
      end

      if (im_we) begin
        index      <= index + {{(AW-1){1'b0}}, 1'b1};
        word_count <= word_count + {{AW{1'b0}}, 1'b1};
      end

      // Low-half acceptance schedules the memory write for the following cycle.
      if (accept) begin
        case (state)
          HDR: n_reg <= in_data[AW:0];
          HI: begin
            hi_reg <= in_data;
            sum    <= sum + in_data;
          end
          LO: begin
            sum      <= sum + in_data;
            im_we    <= 1'b1;
            im_addr  <= index;
            im_wdata <= {hi_reg, in_data};
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: memory writes go through a scoreboard queue,
// status outputs are checked with immediate assertions after each frame step.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        im_we;
  logic [3:0]  im_addr;
  logic [31:0] im_wdata;
  logic        core_rst;
  logic        done;
  logic        err;
  logic [4:0]  word_count;

  int          passes = 0;
  int          checks = 0;
  logic [35:0] exp_q[$];
  logic [31:0] prog[16];
  bit          gaps = 1'b0;

  prog_loader #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .sys_rst(sys_rst), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .im_we(im_we), .im_addr(im_addr),
    .im_wdata(im_wdata), .core_rst(core_rst), .done(done), .err(err),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (im_we) begin
      checkOutput("we_expected", {31'b0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) begin
        logic [35:0] e;
        e = exp_q.pop_front();
        checkOutput("im_addr", {28'b0, im_addr}, {28'b0, e[35:32]});
        checkOutput("im_wdata", im_wdata, e[31:0]);
      end
    end
  end

  task automatic sendWord(input logic [15:0] w);
    int budget;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b1;
    in_data  = w;
    budget   = 0;
    while (!in_ready && budget < 100) begin
      @(posedge clk);
      #1;
      budget++;
    end
    if (!in_ready) begin
      checkOutput("ready_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pulseStart();
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h0000;
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
    checkOutput({tag, "_im_we"}, {31'b0, im_we}, 32'd0);
    checkOutput({tag, "_im_addr"}, {28'b0, im_addr}, 32'd0);
    checkOutput({tag, "_im_wdata"}, im_wdata, 32'd0);
    checkOutput({tag, "_core_rst"}, {31'b0, core_rst}, 32'd1);
    checkOutput({tag, "_done"}, {31'b0, done}, 32'd0);
    checkOutput({tag, "_err"}, {31'b0, err}, 32'd0);
    checkOutput({tag, "_word_count"}, {27'b0, word_count}, 32'd0);
  endtask

  // One full session: start, header, payload from prog[], checksum (+delta to corrupt it).
  task automatic applyStimulus(input string tag, input logic [15:0] hdr, input logic [15:0] chk_delta,
                               input int start_in_lo);
    int          n;
    bit          hdr_bad;
    logic [15:0] s;
    n       = int'(hdr[4:0]);
    hdr_bad = (hdr[15:8] != 8'hA5) || (hdr[7:5] != 3'b000) || (n == 0) || (n > 16);
    pulseStart();
    checkOutput({tag, "_start_ready"}, {31'b0, in_ready}, 32'd1);
    checkOutput({tag, "_start_status"}, {29'b0, core_rst, done, err}, 32'b100);
    checkOutput({tag, "_start_count"}, {27'b0, word_count}, 32'd0);
    sendWord(hdr);
    if (hdr_bad) begin
      checkOutput({tag, "_hdr_status"}, {29'b0, core_rst, done, err}, 32'b101);
      checkOutput({tag, "_hdr_ready"}, {31'b0, in_ready}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput({tag, "_hdr_noq"}, exp_q.size(), 32'd0);
      return;
    end
    s = 16'h0000;
    for (int i = 0; i < n; i++) begin
      sendWord(prog[i][31:16]);
      if (i == start_in_lo) begin
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput({tag, "_lo_start_ready"}, {31'b0, in_ready}, 32'd1);
      end
      exp_q.push_back({i[3:0], prog[i]});
      sendWord(prog[i][15:0]);
      checkOutput({tag, "_we_latency"}, {31'b0, im_we}, 32'd1);
      s = s + prog[i][31:16] + prog[i][15:0];
    end
    sendWord(s + chk_delta);
    if (chk_delta == 16'h0000) begin
      checkOutput({tag, "_end_status"}, {29'b0, core_rst, done, err}, 32'b010);
    end else begin
      checkOutput({tag, "_end_status"}, {29'b0, core_rst, done, err}, 32'b101);
    end
    checkOutput({tag, "_end_count"}, {27'b0, word_count}, n);
    checkOutput({tag, "_end_ready"}, {31'b0, in_ready}, 32'd0);
    checkOutput({tag, "_end_q"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    sys_rst  = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    sys_rst = 1'b0;
    checkResetValues("reset");

    $display("[TB] nominal N=2");
    prog[0] = 32'h08410005;
    prog[1] = 32'hD8000000;
    applyStimulus("nominal", 16'hA502, 16'h0000, -1);

    $display("[TB] bad checksum");
    applyStimulus("badchk", 16'hA502, 16'h0001, -1);

    $display("[TB] header rejects");
    applyStimulus("hdr_n0", 16'hA500, 16'h0000, -1);
    applyStimulus("hdr_n17", 16'hA511, 16'h0000, -1);
    applyStimulus("hdr_magic", 16'h5A02, 16'h0000, -1);
    applyStimulus("hdr_rsvd", 16'hA5E2, 16'h0000, -1);

    $display("[TB] full depth with gaps");
    for (int i = 0; i < 16; i++) prog[i] = 32'hFFFFFFFF;
    gaps = 1'b1;
    applyStimulus("full", 16'hA510, 16'h0000, -1);
    gaps = 1'b0;

    $display("[TB] reset mid-frame");
    prog[0] = 32'h08410005;
    prog[1] = 32'hD8000000;
    pulseStart();
    sendWord(16'hA502);
    sendWord(prog[0][31:16]);
    exp_q.push_back({4'd0, prog[0]});
    sendWord(prog[0][15:0]);
    sendWord(prog[1][31:16]);
    sys_rst = 1'b1;
    @(posedge clk);
    #1;
    sys_rst = 1'b0;
    checkResetValues("midrst");
    checkOutput("midrst_q", exp_q.size(), 32'd0);
    applyStimulus("reload", 16'hA502, 16'h0000, -1);

    $display("[TB] start pulsed in LO");
    prog[2] = 32'h12345678;
    applyStimulus("lostart", 16'hA503, 16'h0000, 1);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("final_q", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Host-side program loader that writes the 16-entry, 32-bit instruction memory of the processor core. It receives a framed stream of 16-bit words over a valid/ready handshake and pairs the words into instructions. It writes each instruction through a registered memory write port, checks a 16-bit additive checksum, and then releases the core from reset. While a load is in progress, or after a failed load, the core is held in reset.

## Interface
Parameters:
- DEPTH, 16: instruction memory entries; the maximum instruction count per frame.
- AW, 4: instruction address width, equal to log2(DEPTH).

Ports:
- clk  in  1  system clock; all logic acts on its rising edge.
- sys_rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse that begins a load session.
- in_valid  in  1  stream word valid.
- in_ready  out  1  loader can accept a word.
- in_data  in  16  stream word.
- im_we  out  1  instruction memory write enable, one-cycle pulse.
- im_addr  out  AW  instruction memory write address.
- im_wdata  out  32  instruction word, {high half, low half}.
- core_rst  out  1  reset to the core; high means the core is held.
- done  out  1  load succeeded; sticky until the next start or reset.
- err  out  1  load failed; sticky until the next start or reset.
- word_count  out  AW+1  number of instructions written in the current or last session.

## Operation
- A word transfers on any cycle with in_valid && in_ready. No other cycle has any effect on stream state.
- Frame format, in order:
  - Header: [15:8] = 8'hA5, [7:5] = 0, [4:0] = N, with 1 ≤ N ≤ DEPTH.
  - 2N payload words, alternating high half then low half of each instruction.
  - One checksum word: the mod-2^16 sum of all 2N payload words. The header is excluded.
- States: IDLE, HDR, HI, LO, CHK, DONE, ERR.
- IDLE:
  - in_ready = 0.
  - start → HDR. On that transition: clear done, err, word_count, index and running sum; set core_rst = 1.
- HDR: accept one word.
  - Bad magic, nonzero [7:5], N = 0 or N > DEPTH → ERR.
  - Otherwise latch N → HI.
- HI: accept a word, latch it as the high half, add it to the sum → LO.
- LO: accept a word and add it to the sum. Schedule a write of {hi, word} at address index.
  - If index == N−1 → CHK.
  - Otherwise → HI.
- Write port: im_we pulses for exactly the cycle after the LO acceptance.
  - In that cycle im_addr = index and im_wdata = the assembled word.
  - index and word_count increment at the end of that cycle.
  - When im_we is low, im_addr and im_wdata hold their last values.
- CHK: accept one word.
  - Equal to the running sum → DONE.
  - Otherwise → ERR.
- DONE: done = 1, core_rst = 0, in_ready = 0.
- ERR: err = 1, core_rst = 1, in_ready = 0. Instructions already written are not rolled back.
- start:
  - In DONE or ERR, start behaves exactly as it does from IDLE.
  - In HDR, HI, LO and CHK, start is ignored (no abort).
- Running sum: 16-bit, wraps silently. Carry out is discarded.

## Timing
- Reset values: in_ready = 0, im_we = 0, im_addr = 0, im_wdata = 0, core_rst = 1, done = 0, err = 0, word_count = 0. State is IDLE.
- sys_rst mid-frame: the next cycle is IDLE with the reset values above. A partially loaded memory is not cleared.
- in_ready is a registered output.
  - It is high from the cycle after start through the cycle in which the checksum word transfers.
  - It stays high during the im_we cycle, so back-to-back words (one per cycle) are accepted without stalls.
- in_valid may deassert between any two words. The loader waits indefinitely; there is no timeout.
- Write latency: im_we is high in cycle t+1 for a low half accepted in cycle t.
- Completion:
  - done/err are set, and core_rst updates, in the cycle after the checksum transfers.
  - For a header error, they update in the cycle after the header transfers.
- Minimum frame time at full rate: 2N + 2 transfer cycles. done rises 1 cycle after the last transfer.
- start and a transfer in the same cycle while in IDLE, DONE or ERR: the transfer is ignored (in_ready is 0).

## Test plan
- Nominal N = 2:
  - Stimulus: start, then A5 header 0xA502; payload 0x0841, 0x0005, 0xD800, 0x0000; checksum 0xE046, all back-to-back.
  - Required: im_we pulses at addr 0 with 0x08410005, then addr 1 with 0xD8000000.
  - Required: done = 1, core_rst = 0, word_count = 2, exactly one cycle after the checksum transfer.
- Bad checksum:
  - Stimulus: same frame with checksum 0xE047.
  - Required: both writes still occur; err = 1, done = 0, core_rst stays 1.
- Header rejects:
  - Stimulus: 0xA500 (N = 0), then 0xA511 (N = 17), then 0x5A02 (bad magic), each in its own session.
  - Required: each gives err = 1 one cycle after the header; no im_we; in_ready drops.
- Full depth with wrap:
  - Stimulus: N = 16, every payload word 0xFFFF, checksum 0xFFE0 (32 × 0xFFFF mod 2^16), random in_valid gaps.
  - Required: 16 writes at addresses 0..15, data 0xFFFFFFFF; word_count = 16; done = 1.
- Reset and restart:
  - Stimulus: sys_rst asserted after the 3rd payload word; then start and the nominal frame. Separately, start pulsed while in LO.
  - Required: after reset, all outputs return to reset values and the reload succeeds. The start pulse in LO has no effect on the session.
